// File: rtl/hazard_if.sv
// hazard_if: pipeline-side signals of the P7 hazard controller.
// The pipeline drives the master side; hazard_ctrl sits on the slave side.
interface hazard_if;
   logic        req;
   logic [4:0]  D_rs;
   logic [4:0]  D_rt;
   logic [1:0]  D_Tuse_rs;
   logic [1:0]  D_Tuse_rt;
   logic        D_is_md;
   logic        D_is_eret;
   logic [4:0]  E_rs;
   logic [4:0]  E_rt;
   logic [4:0]  E_waddr;
   logic [2:0]  E_Tnew;
   logic [4:0]  M_waddr;
   logic [2:0]  M_Tnew;
   logic [4:0]  W_waddr;
   logic        E_md_start;
   logic        E_md_type;
   logic        E_mtc0_epc;
   logic        M_mtc0_epc;
   logic        stall;
   logic        md_busy;
   logic [1:0]  fwd_D_rs_sel;
   logic [1:0]  fwd_D_rt_sel;
   logic [1:0]  fwd_E_rs_sel;
   logic [1:0]  fwd_E_rt_sel;
   logic [31:0] stall_cnt;
   logic [31:0] md_stall_cnt;

   modport master (
      output req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md, D_is_eret,
             E_rs, E_rt, E_waddr, E_Tnew, M_waddr, M_Tnew, W_waddr,
             E_md_start, E_md_type, E_mtc0_epc, M_mtc0_epc,
      input  stall, md_busy, fwd_D_rs_sel, fwd_D_rt_sel, fwd_E_rs_sel,
             fwd_E_rt_sel, stall_cnt, md_stall_cnt
   );

   modport slave (
      input  req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md, D_is_eret,
             E_rs, E_rt, E_waddr, E_Tnew, M_waddr, M_Tnew, W_waddr,
             E_md_start, E_md_type, E_mtc0_epc, M_mtc0_epc,
      output stall, md_busy, fwd_D_rs_sel, fwd_D_rt_sel, fwd_E_rs_sel,
             fwd_E_rt_sel, stall_cnt, md_stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding control for the P7 pipeline, with HI/LO busy tracking.
// Define HAZARD_PERF_EN to build the saturating stall performance counters.
module hazard_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic     clk,
   input logic     reset,
   hazard_if.slave hz
);
   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [CNT_W-1:0] md_cnt_r;
   logic [CNT_W-1:0] md_cnt_nxt_s;
   logic             md_busy_r;
   logic             data_stall_s;
   logic             md_stall_s;
   logic             eret_stall_s;
   logic             stall_s;
   logic [1:0]       fwd_d_rs_s;
   logic [1:0]       fwd_d_rt_s;
   logic [1:0]       fwd_e_rs_s;
   logic [1:0]       fwd_e_rt_s;

   // A producer stalls the operand while its result is further away than the consumer's need.
   function automatic logic data_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] e_waddr, input logic [2:0] e_tnew,
                                        input logic [4:0] m_waddr, input logic [2:0] m_tnew);
      logic hit;
      hit = 1'b0;
      if ((src != 5'd0) && (tuse != 2'd3)) begin
         hit = ((e_waddr == src) && (e_tnew > {1'b0, tuse})) ||
               ((m_waddr == src) && (m_tnew > {1'b0, tuse}));
      end else begin
         hit = 1'b0;
      end
      return hit;
   endfunction

   function automatic logic [1:0] fwd_d(input logic [4:0] src,
                                        input logic [4:0] e_waddr, input logic [2:0] e_tnew,
                                        input logic [4:0] m_waddr, input logic [2:0] m_tnew,
                                        input logic [4:0] w_waddr);
      logic [1:0] sel;
      sel = 2'd0;
      if (src == 5'd0) begin
         sel = 2'd0;
      end else if ((e_waddr == src) && (e_tnew == 3'd0)) begin
         sel = 2'd1;
      end else if ((m_waddr == src) && (m_tnew == 3'd0)) begin
         sel = 2'd2;
      end else if (w_waddr == src) begin
         sel = 2'd3;
      end else begin
         sel = 2'd0;
      end
      return sel;
   endfunction

   function automatic logic [1:0] fwd_e(input logic [4:0] src,
                                        input logic [4:0] m_waddr, input logic [2:0] m_tnew,
                                        input logic [4:0] w_waddr);
      logic [1:0] sel;
      sel = 2'd0;
      if (src == 5'd0) begin
         sel = 2'd0;
      end else if ((m_waddr == src) && (m_tnew == 3'd0)) begin
         sel = 2'd2;
      end else if (w_waddr == src) begin
         sel = 2'd3;
      end else begin
         sel = 2'd0;
      end
      return sel;
   endfunction

   // Stall terms and forwarding selects.
   always_comb begin
      data_stall_s = data_hazard(hz.D_rs, hz.D_Tuse_rs, hz.E_waddr, hz.E_Tnew, hz.M_waddr, hz.M_Tnew) ||
                     data_hazard(hz.D_rt, hz.D_Tuse_rt, hz.E_waddr, hz.E_Tnew, hz.M_waddr, hz.M_Tnew);
      md_stall_s   = hz.D_is_md && (md_busy_r || hz.E_md_start);
      eret_stall_s = hz.D_is_eret && (hz.E_mtc0_epc || hz.M_mtc0_epc);
      if (hz.req) begin
         stall_s = 1'b0;
      end else begin
         stall_s = data_stall_s || md_stall_s || eret_stall_s;
      end
      fwd_d_rs_s = fwd_d(hz.D_rs, hz.E_waddr, hz.E_Tnew, hz.M_waddr, hz.M_Tnew, hz.W_waddr);
      fwd_d_rt_s = fwd_d(hz.D_rt, hz.E_waddr, hz.E_Tnew, hz.M_waddr, hz.M_Tnew, hz.W_waddr);
      fwd_e_rs_s = fwd_e(hz.E_rs, hz.M_waddr, hz.M_Tnew, hz.W_waddr);
      fwd_e_rt_s = fwd_e(hz.E_rt, hz.M_waddr, hz.M_Tnew, hz.W_waddr);
   end

   // A start killed by req never loads; a start while busy restarts the count.
   always_comb begin
      md_cnt_nxt_s = md_cnt_r;
      if (hz.E_md_start && !hz.req) begin
         md_cnt_nxt_s = hz.E_md_type ? DIV_LOAD : MULT_LOAD;
      end else if (md_cnt_r != CNT_ZERO) begin
         md_cnt_nxt_s = md_cnt_r - CNT_ONE;
      end else begin
         md_cnt_nxt_s = md_cnt_r;
      end
   end

   // Mult/div occupancy counter and its registered busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_r  <= CNT_ZERO;
         md_busy_r <= 1'b0;
      end else begin
         md_cnt_r  <= md_cnt_nxt_s;
         md_busy_r <= (md_cnt_nxt_s != CNT_ZERO);
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] md_stall_cnt_r;

   // Saturating stall counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r    <= 32'd0;
         md_stall_cnt_r <= 32'd0;
      end else begin
         if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (md_stall_s && (md_stall_cnt_r != 32'hFFFF_FFFF)) begin
            md_stall_cnt_r <= md_stall_cnt_r + 32'd1;
         end else begin
            md_stall_cnt_r <= md_stall_cnt_r;
         end
      end
   end

   assign hz.stall_cnt    = stall_cnt_r;
   assign hz.md_stall_cnt = md_stall_cnt_r;
`else
   assign hz.stall_cnt    = 32'd0;
   assign hz.md_stall_cnt = 32'd0;
`endif

   assign hz.stall        = stall_s;
   assign hz.md_busy      = md_busy_r;
   assign hz.fwd_D_rs_sel = fwd_d_rs_s;
   assign hz.fwd_D_rt_sel = fwd_d_rt_s;
   assign hz.fwd_E_rs_sel = fwd_e_rs_s;
   assign hz.fwd_E_rt_sel = fwd_e_rt_s;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table for the combinational paths plus
// hand-written sequences for the mult/div counter and the perf counters.
module tb_hazard_ctrl;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   hazard_if hz ();

   hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       req;
      logic [4:0] d_rs;
      logic [4:0] d_rt;
      logic [1:0] tu_rs;
      logic [1:0] tu_rt;
      logic       eret;
      logic [4:0] e_rs;
      logic [4:0] e_rt;
      logic [4:0] e_waddr;
      logic [2:0] e_tnew;
      logic [4:0] m_waddr;
      logic [2:0] m_tnew;
      logic [4:0] w_waddr;
      logic       e_epc;
      logic       m_epc;
      logic       x_stall;
      logic [1:0] x_drs;
      logic [1:0] x_drt;
      logic [1:0] x_ers;
      logic [1:0] x_ert;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic req, input logic [4:0] d_rs, input logic [4:0] d_rt,
                               input logic [1:0] tu_rs, input logic [1:0] tu_rt, input logic eret,
                               input logic [4:0] e_rs, input logic [4:0] e_rt,
                               input logic [4:0] e_waddr, input logic [2:0] e_tnew,
                               input logic [4:0] m_waddr, input logic [2:0] m_tnew,
                               input logic [4:0] w_waddr, input logic e_epc, input logic m_epc,
                               input logic x_stall, input logic [1:0] x_drs, input logic [1:0] x_drt,
                               input logic [1:0] x_ers, input logic [1:0] x_ert);
      vec_t v;
      v.req = req; v.d_rs = d_rs; v.d_rt = d_rt; v.tu_rs = tu_rs; v.tu_rt = tu_rt;
      v.eret = eret; v.e_rs = e_rs; v.e_rt = e_rt; v.e_waddr = e_waddr; v.e_tnew = e_tnew;
      v.m_waddr = m_waddr; v.m_tnew = m_tnew; v.w_waddr = w_waddr; v.e_epc = e_epc;
      v.m_epc = m_epc; v.x_stall = x_stall; v.x_drs = x_drs; v.x_drt = x_drt;
      v.x_ers = x_ers; v.x_ert = x_ert;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clr_inputs();
      hz.req = 1'b0; hz.D_rs = 5'd0; hz.D_rt = 5'd0; hz.D_Tuse_rs = 2'd3; hz.D_Tuse_rt = 2'd3;
      hz.D_is_md = 1'b0; hz.D_is_eret = 1'b0; hz.E_rs = 5'd0; hz.E_rt = 5'd0;
      hz.E_waddr = 5'd0; hz.E_Tnew = 3'd0; hz.M_waddr = 5'd0; hz.M_Tnew = 3'd0;
      hz.W_waddr = 5'd0; hz.E_md_start = 1'b0; hz.E_md_type = 1'b0;
      hz.E_mtc0_epc = 1'b0; hz.M_mtc0_epc = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      clr_inputs();
      hz.D_Tuse_rs = 2'd0;
      hz.D_Tuse_rt = 2'd0;

      // req d_rs d_rt trs trt eret e_rs e_rt e_wa e_tn m_wa m_tn w_wa eepc mepc | stall drs drt ers ert
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 5, 0, 0, 3, 0, 0, 0, 5, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      vecs[2]  = mk(0, 5, 0, 0, 3, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0,  1, 0, 0, 0, 0);
      vecs[3]  = mk(0, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0,  0, 3, 0, 0, 0);
      vecs[4]  = mk(0, 0, 8, 3, 1, 0, 0, 0, 8, 0, 8, 0, 0, 0, 0,  0, 0, 1, 0, 0);
      vecs[5]  = mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      vecs[6]  = mk(0, 7, 0, 2, 3, 0, 0, 0, 7, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      vecs[7]  = mk(0, 7, 0, 1, 3, 0, 0, 0, 7, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      vecs[8]  = mk(0, 7, 0, 3, 3, 0, 0, 0, 7, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      vecs[9]  = mk(1, 7, 0, 1, 3, 0, 0, 0, 7, 2, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
      vecs[10] = mk(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0);
      vecs[11] = mk(0, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0);
      vecs[12] = mk(0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0);
      vecs[13] = mk(0, 0, 0, 3, 3, 0, 9, 4, 0, 0, 9, 0, 4, 0, 0,  0, 0, 0, 2, 3);
      vecs[14] = mk(0, 0, 0, 3, 3, 0, 9, 9, 0, 0, 9, 0, 9, 0, 0,  0, 0, 0, 2, 2);
      vecs[15] = mk(0, 6, 0, 3, 3, 0, 0, 0, 0, 0, 6, 0, 6, 0, 0,  0, 2, 0, 0, 0);
      vecs[16] = mk(0, 4, 3, 0, 0, 0, 0, 0, 0, 0, 3, 2, 4, 0, 0,  1, 3, 0, 0, 0);
      vecs[17] = mk(0, 0, 11, 3, 2, 0, 0, 0, 11, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      // Reset state with every input at 0
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_md_busy", 32'(hz.md_busy), 32'd0);
      chk("rst_stall", 32'(hz.stall), 32'd0);
      chk("rst_fwd_d_rs", 32'(hz.fwd_D_rs_sel), 32'd0);
      chk("rst_fwd_e_rt", 32'(hz.fwd_E_rt_sel), 32'd0);
      chk("rst_stall_cnt", hz.stall_cnt, 32'd0);
      chk("rst_md_stall_cnt", hz.md_stall_cnt, 32'd0);
      @(negedge clk);

      for (int i = 0; i < NVEC; i++) begin
         hz.req = vecs[i].req; hz.D_rs = vecs[i].d_rs; hz.D_rt = vecs[i].d_rt;
         hz.D_Tuse_rs = vecs[i].tu_rs; hz.D_Tuse_rt = vecs[i].tu_rt; hz.D_is_eret = vecs[i].eret;
         hz.E_rs = vecs[i].e_rs; hz.E_rt = vecs[i].e_rt; hz.E_waddr = vecs[i].e_waddr;
         hz.E_Tnew = vecs[i].e_tnew; hz.M_waddr = vecs[i].m_waddr; hz.M_Tnew = vecs[i].m_tnew;
         hz.W_waddr = vecs[i].w_waddr; hz.E_mtc0_epc = vecs[i].e_epc; hz.M_mtc0_epc = vecs[i].m_epc;
         #1;
         chk($sformatf("v%0d_stall", i), 32'(hz.stall), 32'(vecs[i].x_stall));
         chk($sformatf("v%0d_fwd_d_rs", i), 32'(hz.fwd_D_rs_sel), 32'(vecs[i].x_drs));
         chk($sformatf("v%0d_fwd_d_rt", i), 32'(hz.fwd_D_rt_sel), 32'(vecs[i].x_drt));
         chk($sformatf("v%0d_fwd_e_rs", i), 32'(hz.fwd_E_rs_sel), 32'(vecs[i].x_ers));
         chk($sformatf("v%0d_fwd_e_rt", i), 32'(hz.fwd_E_rt_sel), 32'(vecs[i].x_ert));
         @(negedge clk);
      end

      // Mult: stall on start cycle plus 5 busy cycles, then release
      clr_inputs();
      do_reset();
      hz.E_md_start = 1'b1; hz.E_md_type = 1'b0; hz.D_is_md = 1'b1;
      #1;
      chk("mult_start_stall", 32'(hz.stall), 32'd1);
      chk("mult_start_busy", 32'(hz.md_busy), 32'd0);
      tick();
      hz.E_md_start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("mult_busy_c%0d", c), 32'(hz.md_busy), 32'd1);
         chk($sformatf("mult_stall_c%0d", c), 32'(hz.stall), 32'd1);
         tick();
      end
      #1;
      chk("mult_done_busy", 32'(hz.md_busy), 32'd0);
      chk("mult_done_stall", 32'(hz.stall), 32'd0);
`ifdef HAZARD_PERF_EN
      chk("perf_stall_cnt", hz.stall_cnt, 32'd6);
      chk("perf_md_stall_cnt", hz.md_stall_cnt, 32'd6);
`else
      chk("perf_stall_cnt", hz.stall_cnt, 32'd0);
      chk("perf_md_stall_cnt", hz.md_stall_cnt, 32'd0);
`endif
      tick();

      // Div start killed by req in the same cycle
      hz.E_md_start = 1'b1; hz.E_md_type = 1'b1; hz.req = 1'b1; hz.D_is_md = 1'b1;
      #1;
      chk("div_req_stall", 32'(hz.stall), 32'd0);
      tick();
      hz.E_md_start = 1'b0; hz.req = 1'b0;
      #1;
      chk("div_req_busy", 32'(hz.md_busy), 32'd0);
      chk("div_req_stall_after", 32'(hz.stall), 32'd0);
      hz.D_is_md = 1'b0;
      tick();

      // Restart: mult then div one cycle later -> 10 busy cycles from the reload
      hz.E_md_start = 1'b1; hz.E_md_type = 1'b0;
      tick();
      hz.E_md_type = 1'b1;
      tick();
      hz.E_md_start = 1'b0;
      for (int c = 0; c < 9; c++) tick();
      #1;
      chk("restart_busy_last", 32'(hz.md_busy), 32'd1);
      tick();
      #1;
      chk("restart_busy_end", 32'(hz.md_busy), 32'd0);
      tick();

      // req during a busy mult: count runs to completion unchanged
      hz.E_md_start = 1'b1; hz.E_md_type = 1'b0;
      tick();
      hz.E_md_start = 1'b0; hz.req = 1'b1;
      tick();
      tick();
      hz.req = 1'b0;
      tick();
      tick();
      #1;
      chk("req_busy_last", 32'(hz.md_busy), 32'd1);
      tick();
      #1;
      chk("req_busy_end", 32'(hz.md_busy), 32'd0);
      tick();

      // Reset mid-div with md_cnt = 7
      hz.E_md_start = 1'b1; hz.E_md_type = 1'b1; hz.D_is_md = 1'b1;
      tick();
      hz.E_md_start = 1'b0;
      tick();
      tick();
      tick();
      #1;
      chk("div_mid_busy", 32'(hz.md_busy), 32'd1);
      reset = 1'b1;
      tick();
      #1;
      chk("div_rst_busy", 32'(hz.md_busy), 32'd0);
      chk("div_rst_stall_cnt", hz.stall_cnt, 32'd0);
      chk("div_rst_md_stall_cnt", hz.md_stall_cnt, 32'd0);
      reset = 1'b0;
      hz.D_is_md = 1'b0;
      tick();
      #1;
      chk("div_rst_busy_after", 32'(hz.md_busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
